alu_issue_reg: RTL and testbench



---
 rtl/alu_issue_reg.sv | 159 +++++++++++++++
 tb/tb_alu_issue_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_reg.sv
// alu_issue_reg: one-entry ID/EX register in front of the 32-bit ALU.
// Captures decoded operands and maps ALUOp/funct to the ALU 4-bit operation code.
// The outputs are presented to the ALU under a valid/ready handshake, with stall
// and flush support.
// Optional feature: define ALU_FORWARD_EN to add EX/MEM and MEM/WB operand forwarding.
module alu_issue_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_aluop,
    input  logic [5:0]  in_funct,
    input  logic        in_alusrc,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [3:0]  operation,
    output logic [31:0] store_data,
    output logic        illegal
`ifdef ALU_FORWARD_EN
    ,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result
`endif
);

    // Returns {illegal, operation}; unsupported encodings map to 1111, which the ALU turns into 0.
    function automatic logic [4:0] f_decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] res;
        res = 5'b1_1111;
        case (aluop)
            2'b00: res = 5'b0_0010;
            2'b01: res = 5'b0_0110;
            2'b10: begin
                case (funct)
                    6'b100000: res = 5'b0_0010;
                    6'b100010: res = 5'b0_0110;
                    6'b100100: res = 5'b0_0000;
                    6'b100101: res = 5'b0_0001;
                    6'b101010: res = 5'b0_0111;
                    6'b100111: res = 5'b0_1100;
                    default:   res = 5'b1_1111;
                endcase
            end
            default: res = 5'b1_1111;
        endcase
        return res;
    endfunction

    logic        r_vld_p1;
    logic [3:0]  r_op_p1;
    logic        r_illegal_p1;
    logic        r_alusrc_p1;
    logic [31:0] r_rs_data_p1;
    logic [31:0] r_rt_data_p1;
    logic [31:0] r_imm_p1;
    logic        w_load;
    logic [4:0]  w_dec;
    logic [31:0] w_rs_opnd;
    logic [31:0] w_rt_opnd;

    assign in_ready = !r_vld_p1 || out_ready;
    assign w_load   = in_valid && in_ready;
    assign w_dec    = f_decode(in_aluop, in_funct);

    // ---- p0 -> p1: capture the decode-stage instruction; flush wins over load ----
`ifdef ALU_FORWARD_EN
    logic [4:0] r_rs_p1;
    logic [4:0] r_rt_p1;

    // Source register numbers are only needed to match against forwarding destinations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rs_p1 <= '0;
            r_rt_p1 <= '0;
        end else if (!flush && w_load) begin
            r_rs_p1 <= in_rs;
            r_rt_p1 <= in_rt;
        end
    end
`else
    logic [9:0] w_unused_regs;
    assign w_unused_regs = {in_rs, in_rt};
`endif

    // Holds the instruction; a stall leaves everything in place, a drain or flush only clears valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1     <= 1'b0;
            r_op_p1      <= 4'b0000;
            r_illegal_p1 <= 1'b0;
            r_alusrc_p1  <= 1'b0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
        end else if (flush) begin
            r_vld_p1     <= 1'b0;
        end else if (w_load) begin
            r_vld_p1     <= 1'b1;
            r_op_p1      <= w_dec[3:0];
            r_illegal_p1 <= w_dec[4];
            r_alusrc_p1  <= in_alusrc;
            r_rs_data_p1 <= in_rs_data;
            r_rt_data_p1 <= in_rt_data;
            r_imm_p1     <= in_imm;
        end else if (out_ready) begin
            r_vld_p1     <= 1'b0;
        end
    end

`ifdef ALU_FORWARD_EN
    // Newest producer wins: EX/MEM over MEM/WB over the held register file data; r0 never forwards.
    function automatic logic [31:0] f_fwd(input logic [4:0] rsrc, input logic [31:0] held,
                                          input logic ex_we, input logic [4:0] ex_rd,
                                          input logic [31:0] ex_res, input logic wb_we,
                                          input logic [4:0] wb_rd, input logic [31:0] wb_res);
        logic [31:0] val;
        val = held;
        if (ex_we && ex_rd != 5'd0 && ex_rd == rsrc)
            val = ex_res;
        else if (wb_we && wb_rd != 5'd0 && wb_rd == rsrc)
            val = wb_res;
        return val;
    endfunction

    // Operand selection is combinational so late results reach an instruction held during a stall.
    always_comb begin
        w_rs_opnd = f_fwd(r_rs_p1, r_rs_data_p1, exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result);
        w_rt_opnd = f_fwd(r_rt_p1, r_rt_data_p1, exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result);
    end
`else
    // Without forwarding, hazards are resolved upstream and held data is used directly.
    always_comb begin
        w_rs_opnd = r_rs_data_p1;
        w_rt_opnd = r_rt_data_p1;
    end
`endif

    assign out_valid  = r_vld_p1;
    assign operation  = r_op_p1;
    assign illegal    = r_illegal_p1;
    assign data_a     = w_rs_opnd;
    assign store_data = w_rt_opnd;
    assign data_b     = r_alusrc_p1 ? r_imm_p1 : w_rt_opnd;

endmodule

// File: tb/tb_alu_issue_reg.sv
// Directed bench for alu_issue_reg; forwarding cases run when ALU_FORWARD_EN is defined.
module tb_alu_issue_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic        in_alusrc;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [31:0] in_imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  operation;
    logic [31:0] store_data;
    logic        illegal;
`ifdef ALU_FORWARD_EN
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_reg dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluop   (in_aluop),
        .in_funct   (in_funct),
        .in_alusrc  (in_alusrc),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rs_data (in_rs_data),
        .in_rt_data (in_rt_data),
        .in_imm     (in_imm),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_a     (data_a),
        .data_b     (data_b),
        .operation  (operation),
        .store_data (store_data),
        .illegal    (illegal)
`ifdef ALU_FORWARD_EN
        ,
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [5:0] funct, input logic alusrc,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        in_aluop   = aluop;
        in_funct   = funct;
        in_alusrc  = alusrc;
        in_rs_data = rsd;
        in_rt_data = rtd;
        in_imm     = imm;
    endtask

    // Decode table: aluop, funct, expected operation, expected illegal
    logic [1:0] t_aluop [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [5:0] t_funct [8] = '{6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                6'b000000, 6'b100000, 6'b100001, 6'b111111};
    logic [3:0] t_op    [8] = '{4'h6, 4'h0, 4'h1, 4'hC, 4'h6, 4'hF, 4'hF, 4'h2};
    logic       t_ill   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_rs = 5'd0; in_rt = 5'd0;
        drive(2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
`ifdef ALU_FORWARD_EN
        exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
`endif
        step(); step();
        reset = 1'b0;

        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op", {28'd0, operation}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_data_a", data_a, 32'd0);
        check("rst_data_b", data_b, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // slt R-type
        in_valid = 1'b1; out_ready = 1'b1;
        drive(2'b10, 6'b101010, 1'b0, 32'd5, 32'd9, 32'd0);
        step();
        check("slt_valid", {31'd0, out_valid}, 32'd1);
        check("slt_op", {28'd0, operation}, 32'h7);
        check("slt_a", data_a, 32'd5);
        check("slt_b", data_b, 32'd9);
        check("slt_store", store_data, 32'd9);
        check("slt_illegal", {31'd0, illegal}, 32'd0);

        // unsupported funct
        drive(2'b10, 6'b000000, 1'b0, 32'd1, 32'd2, 32'd0);
        step();
        check("bad_valid", {31'd0, out_valid}, 32'd1);
        check("bad_op", {28'd0, operation}, 32'hF);
        check("bad_illegal", {31'd0, illegal}, 32'd1);

        // add with immediate operand B
        drive(2'b00, 6'b000000, 1'b1, 32'd1, 32'd2, 32'hFFFF_FFFC);
        step();
        check("imm_b", data_b, 32'hFFFF_FFFC);
        check("imm_op", {28'd0, operation}, 32'h2);
        check("imm_store", store_data, 32'd2);
        check("imm_a", data_a, 32'd1);

        // remaining decode table, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(t_aluop[i], t_funct[i], 1'b0, 32'd100 + i, 32'd200 + i, 32'd0);
            step();
            check("dec_op", {28'd0, operation}, {28'd0, t_op[i]});
            check("dec_ill", {31'd0, illegal}, {31'd0, t_ill[i]});
            check("dec_a", data_a, 32'd100 + i);
        end

        // stall: A held while B waits
        drive(2'b01, 6'd0, 1'b0, 32'h11, 32'h22, 32'd0);
        step();
        out_ready = 1'b0;
        drive(2'b00, 6'd0, 1'b0, 32'h33, 32'h44, 32'd0);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_a", data_a, 32'h11);
            check("stall_b", data_b, 32'h22);
            check("stall_op", {28'd0, operation}, 32'h6);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("release_a", data_a, 32'h33);
        check("release_b", data_b, 32'h44);
        check("release_op", {28'd0, operation}, 32'h2);

        // drain
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // flush beats a simultaneous load
        in_valid = 1'b1;
        drive(2'b00, 6'd0, 1'b0, 32'h55, 32'h66, 32'd0);
        step();
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        drive(2'b01, 6'd0, 1'b0, 32'h77, 32'h88, 32'd0);
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);

        // flush during a stall
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("stall2_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_flush_valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset while stalled
        in_valid = 1'b1;
        drive(2'b10, 6'b100101, 1'b1, 32'h99, 32'hAA, 32'hBB);
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_b", data_b, 32'hBB);
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_op", {28'd0, operation}, 32'd0);
        check("arst_a", data_a, 32'd0);
        check("arst_b", data_b, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        reset = 1'b0;

`ifdef ALU_FORWARD_EN
        // priority: EX/MEM over MEM/WB over held data
        in_valid = 1'b1; out_ready = 1'b1; in_rs = 5'd3; in_rt = 5'd4;
        drive(2'b00, 6'd0, 1'b0, 32'hAA, 32'hCC, 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
        #1;
        check("fwd_exmem", data_a, 32'h10);
        check("fwd_rt_none", store_data, 32'hCC);
        exmem_regwrite = 1'b0;
        #1;
        check("fwd_memwb", data_a, 32'h20);
        memwb_regwrite = 1'b0;
        #1;
        check("fwd_held", data_a, 32'hAA);
        // register 0 never forwards
        out_ready = 1'b1; in_valid = 1'b1; in_rs = 5'd0;
        drive(2'b00, 6'd0, 1'b0, 32'hBB, 32'hCC, 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h10;
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h20;
        #1;
        check("fwd_r0", data_a, 32'hBB);
        // immediate B is never forwarded, store data is
        out_ready = 1'b1; in_valid = 1'b1; in_rs = 5'd1; in_rt = 5'd7;
        drive(2'b00, 6'd0, 1'b1, 32'h1, 32'h55, 32'h1234);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h77;
        memwb_regwrite = 1'b0;
        #1;
        check("fwd_imm_b", data_b, 32'h1234);
        check("fwd_store", store_data, 32'h77);
        check("fwd_a_none", data_a, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
